// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the register file and its read ports.
// Widths, address/data typedefs and the hardwired-zero register index.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xword_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // x0 is architecturally zero: never stored, never bypassed
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: selects a register from the storage view,
// forces x0 to zero and, when REGFILE_BYPASS_EN is defined, forwards write data.
module regfile_rd_port
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] ad,
    input  logic [XLEN-1:0]   regs [NREG],
`ifdef REGFILE_BYPASS_EN
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              bypass_valid,
`endif
    output logic [XLEN-1:0]   rd
);

    // bypass_valid already excludes x0 and reset, so a match here is always legal to forward
    always_comb begin
        rd = is_x0(ad) ? '0 : regs[ad];
`ifdef REGFILE_BYPASS_EN
        if (bypass_valid && (ad == wr_addr)) begin
            rd = wr_data;
        end
`endif
    end

endmodule

// File: rtl/regfile.sv
// RV32 integer register file: 31 stored registers, x0 hardwired to zero,
// two combinational read ports, one write port. Optional write-through via REGFILE_BYPASS_EN.
module regfile
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ad1,
    input  logic [REG_AW-1:0] ad2,
    input  logic [REG_AW-1:0] ad3,
    input  logic [XLEN-1:0]   wd3,
    input  logic              we,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2
);

    logic [XLEN-1:0] storage [1:NREG-1];
    logic [NREG-1:1] wr_hit;
    logic [XLEN-1:0] view [NREG];

    assign view[0] = '0;

    // Per-register write decode keeps ad3 out of any array index, so x0 simply has no target
    for (genvar g = 1; g < NREG; g++) begin : g_reg
        assign wr_hit[g] = we && (ad3 == reg_addr_t'(g));
        assign view[g]   = storage[g];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                storage[g] <= '0;
            end else if (wr_hit[g]) begin
                storage[g] <= wd3;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic bypass_valid;

    // Gated by rst so outputs stay zero while reset is held, even with we asserted
    assign bypass_valid = we && !rst && !is_x0(ad3);
`endif

    regfile_rd_port u_rd1 (
        .ad           (ad1),
        .regs         (view),
`ifdef REGFILE_BYPASS_EN
        .wr_addr      (ad3),
        .wr_data      (wd3),
        .bypass_valid (bypass_valid),
`endif
        .rd           (rd1)
    );

    regfile_rd_port u_rd2 (
        .ad           (ad2),
        .regs         (view),
`ifdef REGFILE_BYPASS_EN
        .wr_addr      (ad3),
        .wr_data      (wd3),
        .bypass_valid (bypass_valid),
`endif
        .rd           (rd2)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: writes, x0 handling, async reset and same-cycle read/write.
// Expected same-cycle value follows REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile;
    import riscv_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] ad1, ad2, ad3;
    logic [XLEN-1:0]   wd3;
    logic              we;
    logic [XLEN-1:0]   rd1, rd2;

    int compared   = 0;
    int mismatched = 0;

    regfile dut (
        .clk (clk),
        .rst (rst),
        .ad1 (ad1),
        .ad2 (ad2),
        .ad3 (ad3),
        .wd3 (wd3),
        .we  (we),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    always #5 clk = ~clk;

    task automatic write_reg(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
        @(negedge clk);
        ad3 = a;
        wd3 = d;
        we  = 1'b1;
        @(negedge clk);
        we  = 1'b0;
    endtask

    task automatic test_reset();
        logic [REG_AW-1:0] addrs [4] = '{5'd0, 5'd1, 5'd17, 5'd31};
        for (int i = 0; i < 4; i++) begin
            ad1 = addrs[i];
            ad2 = addrs[3 - i];
            #1;
            compared++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL reset_read ad1=%0d ad2=%0d got rd1=%h rd2=%h expected 0/0",
                         addrs[i], addrs[3 - i], rd1, rd2);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        for (int i = 1; i <= 4; i++) begin
            write_reg(5'(i), 32'(i));
        end
        ad1 = 5'd1; ad2 = 5'd2; #1;
        compared++;
        if (rd1 !== 32'd1 || rd2 !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL read_x1_x2 got rd1=%h rd2=%h expected 1/2", rd1, rd2);
        end
        ad1 = 5'd3; ad2 = 5'd4; #1;
        compared++;
        if (rd1 !== 32'd3 || rd2 !== 32'd4) begin
            mismatched++;
            $display("[TB] FAIL read_x3_x4 got rd1=%h rd2=%h expected 3/4", rd1, rd2);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        ad3 = 5'd0; wd3 = 32'd4; we = 1'b1;
        repeat (2) @(negedge clk);
        ad1 = 5'd0; ad2 = 5'd0; #1;
        compared++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL x0_write_ignored got rd1=%h rd2=%h expected 0/0", rd1, rd2);
        end
        we = 1'b0;
        ad1 = 5'd4; #1;
        compared++;
        if (rd1 !== 32'd4) begin
            mismatched++;
            $display("[TB] FAIL x4_after_x0_write got %h expected 4", rd1);
        end
    endtask

    task automatic test_we_low();
        @(negedge clk);
        ad3 = 5'd5; wd3 = 32'hDEADBEEF; we = 1'b0;
        @(negedge clk);
        ad1 = 5'd5; #1;
        compared++;
        if (rd1 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL we_low_no_write got %h expected 0", rd1);
        end
    endtask

    task automatic test_x31();
        write_reg(5'd31, 32'hFFFF_FFFF);
        ad1 = 5'd31; ad2 = 5'd31; #1;
        compared++;
        if (rd1 !== 32'hFFFF_FFFF || rd2 !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("[TB] FAIL x31_all_ones got rd1=%h rd2=%h expected ffffffff", rd1, rd2);
        end
        write_reg(5'd31, 32'h0);
        #1;
        compared++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL x31_cleared got rd1=%h rd2=%h expected 0/0", rd1, rd2);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 1; i <= 4; i += 2) begin
            ad1 = 5'(i); ad2 = 5'(i + 1); #1;
            compared++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL async_reset_x%0d_x%0d got rd1=%h rd2=%h expected 0/0",
                         i, i + 1, rd1, rd2);
            end
        end
        ad1 = 5'd1; ad3 = 5'd1; wd3 = 32'd7; we = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (rd1 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL write_during_reset got %h expected 0", rd1);
        end
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b0;
        #1;
        compared++;
        if (rd1 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL x1_after_reset_release got %h expected 0", rd1);
        end
        write_reg(5'd2, 32'hA5A5_0001);
        ad2 = 5'd2; #1;
        compared++;
        if (rd2 !== 32'hA5A5_0001) begin
            mismatched++;
            $display("[TB] FAIL first_write_after_reset got %h expected a5a50001", rd2);
        end
    endtask

    task automatic test_same_cycle();
        logic [XLEN-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h1234;
`else
        exp_pre = 32'h0;
`endif
        @(negedge clk);
        ad1 = 5'd6; ad2 = 5'd7; ad3 = 5'd6; wd3 = 32'h1234; we = 1'b1;
        #1;
        compared++;
        if (rd1 !== exp_pre) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_rd1 got %h expected %h", rd1, exp_pre);
        end
        compared++;
        if (rd2 !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL same_cycle_other_port got %h expected 0", rd2);
        end
        @(posedge clk);
        #1;
        we  = 1'b0;
        ad2 = 5'd6;
        #1;
        compared++;
        if (rd1 !== 32'h1234 || rd2 !== 32'h1234) begin
            mismatched++;
            $display("[TB] FAIL after_edge_x6 got rd1=%h rd2=%h expected 00001234", rd1, rd2);
        end
    endtask

    initial begin
        rst = 1'b1;
        ad1 = '0; ad2 = '0; ad3 = '0; wd3 = '0; we = 1'b0;
        test_reset();
        test_write_read();
        test_x0();
        test_we_low();
        test_x31();
        test_async_reset();
        test_same_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
